// File: rtl/multicycle_core.sv
// multicycle_core: multicycle MIPS-subset CPU with on-chip control FSM,
// req/ready memory port and a combinational register debug read.
module multicycle_core #(
  parameter int ADDR_W = 16,
  parameter int NUM_REGS = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic [4:0]        dbg_sel,
  output logic [31:0]       dbg_data,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retired,
  output logic              halted
);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_RD, MEM_WR,
    WB_R, WB_I, WB_MEM, BRANCH, JUMP, HALT
  } state_t;
  state_t state, next;
  logic [ADDR_W-1:0] pc;
  logic [31:0] ir, a, b, alu_out, mdr, alu_r, imm, wval;
  logic [31:0] regs [32];
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, wsel;
  logic done, funct_ok, retire, wen;
  assign op = ir[31:26];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  assign funct = ir[5:0];
  assign imm = {{16{ir[15]}}, ir[15:0]};
  assign pc_out = pc;
  // Indices 0 and >= NUM_REGS are never written, so they always read 0
  assign dbg_data = regs[dbg_sel];
  always_comb begin
    alu_r = funct == 6'h20 ? a + b :
            funct == 6'h22 ? a - b :
            funct == 6'h24 ? a & b :
            funct == 6'h25 ? a | b :
            {31'b0, $signed(a) < $signed(b)};
    funct_ok = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  end
  always_ff @(posedge clk)
    if (!reset) state <= FETCH;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      FETCH:   if (done) next = DECODE;
      DECODE:  next = op == 6'h00 ? EXEC_R :
                      (op == 6'h23 || op == 6'h2B || op == 6'h08) ? EXEC_I :
                      op == 6'h04 ? BRANCH :
                      op == 6'h02 ? JUMP : HALT;
      EXEC_R:  next = funct_ok ? WB_R : HALT;
      EXEC_I:  next = op == 6'h23 ? MEM_RD : op == 6'h2B ? MEM_WR : WB_I;
      MEM_RD:  if (done) next = WB_MEM;
      MEM_WR:  if (done) next = FETCH;
      WB_R, WB_I, WB_MEM, BRANCH, JUMP: next = FETCH;
      default: next = HALT;
    endcase
  end
  always_comb begin
    mem_req = reset && (state == FETCH || state == MEM_RD || state == MEM_WR);
    mem_we = state == MEM_WR;
    mem_addr = state == FETCH ? pc : alu_out[ADDR_W-1:0];
    mem_wdata = b;
    done = mem_req && mem_ready;
    halted = state == HALT;
    retire = (state inside {WB_R, WB_I, WB_MEM, BRANCH, JUMP}) || (state == MEM_WR && done);
    wsel = state == WB_R ? rd : rt;
    wval = state == WB_MEM ? mdr : alu_out;
    wen = (state inside {WB_R, WB_I, WB_MEM}) && wsel != 5'd0 && 32'(wsel) < NUM_REGS;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      alu_out <= '0;
      mdr <= '0;
      retired <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      retired <= retire;
      if (state == FETCH && done) begin
        ir <= mem_rdata;
        pc <= pc + ADDR_W'(1);
      end
      if (state == DECODE) begin
        a <= regs[rs];
        b <= regs[rt];
        alu_out <= {{(32-ADDR_W){1'b0}}, pc} + imm;
      end
      if (state == EXEC_R) alu_out <= alu_r;
      if (state == EXEC_I) alu_out <= a + imm;
      if (state == MEM_RD && done) mdr <= mem_rdata;
      if (state == BRANCH && a == b) pc <= alu_out[ADDR_W-1:0];
      if (state == JUMP) pc <= ir[ADDR_W-1:0];
      if (wen) regs[wsel] <= wval;
    end
endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed programs; expected retirements are queued and
// checked by a monitor on every retired pulse.
module tb_multicycle_core;
  logic clk = 0, reset = 0, mem_ready = 0, mem_req, mem_we, retired, halted;
  logic [15:0] mem_addr, pc_out;
  logic [31:0] mem_wdata, dbg_data, mem_rdata = 0;
  logic [4:0] dbg_sel = 0;
  typedef struct {logic [15:0] pc; logic [4:0] idx; logic [31:0] val; int cyc;} exp_t;
  exp_t exp_q[$];
  logic [31:0] prog [256];
  logic [31:0] mem [256];
  int checks = 0, errors = 0, cyc = 0, t0 = 0, delay = 0, wcnt = 0, nwr = 0, n0 = 0;
  logic hold = 0, done = 0, wr = 0;
  logic [7:0] waddr = 0;
  logic [31:0] wdat = 0;
  localparam logic [31:0] HLT = 32'hFC000000;

  multicycle_core dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .pc_out(pc_out), .retired(retired), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    done <= reset && mem_req && mem_ready;
    wr <= mem_we;
    waddr <= mem_addr[7:0];
    wdat <= mem_wdata;
    wcnt <= (!reset || (mem_req && mem_ready)) ? 0 : mem_req ? wcnt + 1 : wcnt;
  end

  // Memory model: reloads the program while reset is held, ready after `delay` wait cycles
  always @(negedge clk) begin
    if (!reset) mem = prog;
    else if (done && wr) begin
      mem[waddr] = wdat;
      nwr++;
    end
    mem_ready = !hold && wcnt >= delay;
    mem_rdata = mem[mem_addr[7:0]];
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && retired) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: pc_out %h with nothing expected", pc_out);
        end else begin
          e = exp_q.pop_front();
          dbg_sel = e.idx;
          #1;
          check("retire_pc", 32'(pc_out), 32'(e.pc));
          check($sformatf("retire_r%0d", e.idx), dbg_data, e.val);
          check("retire_cycle", 32'(cyc - t0), 32'(e.cyc));
        end
      end
    end
  end

  function automatic logic [31:0] ity(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] rty(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] f);
    return {6'd0, rs, rt, rd, 5'd0, f};
  endfunction
  task automatic expect_ret(logic [15:0] pc, logic [4:0] idx, logic [31:0] val, int c);
    exp_q.push_back('{pc, idx, val, c});
  endtask
  task automatic clear_prog();
    foreach (prog[i]) prog[i] = 32'd0;
  endtask
  task automatic start(int d);
    reset = 0;
    hold = 0;
    delay = d;
    repeat (3) @(negedge clk);
    reset = 1;
    t0 = cyc;
  endtask
  task automatic wait_to(int n);
    while (cyc - t0 < n) @(negedge clk);
  endtask

  initial begin
    // Straight-line addi/addi/add, zero wait
    clear_prog();
    prog[0] = ity(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = ity(6'h08, 5'd0, 5'd2, 16'hFFFD);
    prog[2] = rty(5'd1, 5'd2, 5'd3, 6'h20);
    prog[3] = HLT;
    repeat (2) @(negedge clk);
    check("reset_pc", 32'(pc_out), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_retired", 32'(retired), 32'd0);
    check("reset_req", 32'(mem_req), 32'd0);
    start(0);
    expect_ret(16'd1, 5'd1, 32'd5, 4);
    expect_ret(16'd2, 5'd2, 32'hFFFFFFFD, 8);
    expect_ret(16'd3, 5'd3, 32'd2, 12);
    wait_to(20);
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_queue", 32'(exp_q.size()), 32'd0);

    // sw then lw with three wait cycles on every request, then illegal opcode at PC=3
    clear_prog();
    prog[0] = ity(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = ity(6'h2B, 5'd0, 5'd1, 16'd4);
    prog[2] = ity(6'h23, 5'd0, 5'd4, 16'd4);
    prog[3] = HLT;
    n0 = nwr;
    start(3);
    expect_ret(16'd1, 5'd1, 32'd5, 7);
    expect_ret(16'd2, 5'd1, 32'd5, 17);
    expect_ret(16'd3, 5'd4, 32'd5, 28);
    for (int k = 13; k <= 16; k++) begin
      wait_to(k);
      check("sw_hold_ctrl", {14'd0, mem_req, mem_we, mem_addr}, {14'd0, 1'b1, 1'b1, 16'd4});
      check("sw_hold_wdata", mem_wdata, 32'd5);
    end
    wait_to(31);
    check("t2_not_halted_yet", 32'(halted), 32'd0);
    wait_to(36);
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_pc", 32'(pc_out), 32'd4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_req_low", 32'(mem_req), 32'd0);
    end
    check("t2_mem4", mem[4], 32'd5);
    check("t2_writes", 32'(nwr - n0), 32'd1);
    check("t2_queue", 32'(exp_q.size()), 32'd0);

    // Not-taken beq, jump, then taken beq looping on itself at PC=7
    clear_prog();
    prog[0] = ity(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = ity(6'h08, 5'd0, 5'd2, 16'hFFFD);
    prog[2] = ity(6'h04, 5'd1, 5'd2, 16'd2);
    prog[3] = {6'h02, 26'd7};
    prog[5] = HLT;
    prog[7] = ity(6'h04, 5'd1, 5'd1, 16'hFFFF);
    start(0);
    expect_ret(16'd1, 5'd1, 32'd5, 4);
    expect_ret(16'd2, 5'd2, 32'hFFFFFFFD, 8);
    expect_ret(16'd3, 5'd1, 32'd5, 11);
    expect_ret(16'd7, 5'd1, 32'd5, 14);
    expect_ret(16'd7, 5'd1, 32'd5, 17);
    expect_ret(16'd7, 5'd1, 32'd5, 20);
    expect_ret(16'd7, 5'd1, 32'd5, 23);
    wait_to(24);
    reset = 0;
    repeat (2) @(negedge clk);
    check("t3_queue", 32'(exp_q.size()), 32'd0);

    // ALU ops, write to $0 dropped, illegal funct halts after EXEC_R
    clear_prog();
    prog[0] = ity(6'h08, 5'd0, 5'd1, 16'hFFFF);
    prog[1] = ity(6'h08, 5'd0, 5'd2, 16'd1);
    prog[2] = rty(5'd1, 5'd2, 5'd3, 6'h2A);
    prog[3] = rty(5'd0, 5'd2, 5'd4, 6'h22);
    prog[4] = ity(6'h08, 5'd0, 5'd0, 16'd9);
    prog[5] = rty(5'd1, 5'd2, 5'd5, 6'h24);
    prog[6] = rty(5'd1, 5'd2, 5'd6, 6'h25);
    prog[7] = rty(5'd2, 5'd1, 5'd7, 6'h2A);
    prog[8] = rty(5'd1, 5'd2, 5'd8, 6'h00);
    start(0);
    expect_ret(16'd1, 5'd1, 32'hFFFFFFFF, 4);
    expect_ret(16'd2, 5'd2, 32'd1, 8);
    expect_ret(16'd3, 5'd3, 32'd1, 12);
    expect_ret(16'd4, 5'd4, 32'hFFFFFFFF, 16);
    expect_ret(16'd5, 5'd0, 32'd0, 20);
    expect_ret(16'd6, 5'd5, 32'd1, 24);
    expect_ret(16'd7, 5'd6, 32'hFFFFFFFF, 28);
    expect_ret(16'd8, 5'd7, 32'd0, 32);
    wait_to(40);
    check("t4_halted", 32'(halted), 32'd1);
    check("t4_pc", 32'(pc_out), 32'd9);
    check("t4_queue", 32'(exp_q.size()), 32'd0);

    // Reset while a store waits for memory
    clear_prog();
    prog[0] = ity(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = ity(6'h2B, 5'd0, 5'd1, 16'd6);
    prog[2] = HLT;
    n0 = nwr;
    start(0);
    expect_ret(16'd1, 5'd1, 32'd5, 4);
    wait_to(5);
    hold = 1;
    wait_to(9);
    check("t6_wait_ctrl", {14'd0, mem_req, mem_we, mem_addr}, {14'd0, 1'b1, 1'b1, 16'd6});
    check("t6_wait_wdata", mem_wdata, 32'd5);
    reset = 0;
    prog[0] = rty(5'd1, 5'd0, 5'd5, 6'h20);
    prog[1] = HLT;
    @(negedge clk);
    check("t6_reset_pc", 32'(pc_out), 32'd0);
    check("t6_reset_req", 32'(mem_req), 32'd0);
    check("t6_reset_halted", 32'(halted), 32'd0);
    hold = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    t0 = cyc;
    expect_ret(16'd1, 5'd5, 32'd0, 4);
    wait_to(10);
    check("t6_no_write", 32'(nwr - n0), 32'd0);
    check("t6_halted", 32'(halted), 32'd1);
    check("t6_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
